// File: rtl/mips_pkg.sv
// Shared MIPS write-back types: register/data widths and the write request record.
package mips_pkg;
  localparam int REG_ADR_W = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_ADR_W-1:0] adr;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] adr_onehot(input logic [REG_ADR_W-1:0] a);
    adr_onehot    = '0;
    adr_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for slow write-back results; exposes its storage so the
// arbiter can build the pending mask and forward from queued entries.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  wb_req_t                      wr,
  output wb_req_t                      rd,
  output logic                         full,
  output logic                         empty,
  output wb_req_t [DEPTH-1:0]          entries,
  output logic [DEPTH-1:0]             valid,
  output logic [$clog2(DEPTH)-1:0]     head
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t [DEPTH-1:0] mem;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it unless the slot is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr;
  end

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++)
      valid[i] = {1'b0, AW'(i) - rd_ptr} < count;
  end

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd      = mem[rd_ptr];
  assign entries = mem;
  assign head    = rd_ptr;
endmodule

// File: rtl/mips_wb_arbiter.sv
// Merges ALU and buffered MEM/MDU results onto the register file write port.
// Define WB_FORWARD_EN to forward the youngest queued value to R1Adr/R2Adr.
module mips_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_adr,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_adr,
  input  logic [31:0] mem_data,
  output logic        WE,
  output logic [4:0]  WAdr,
  output logic [31:0] Din,
  output logic [31:0] pending,
  input  logic [4:0]  R1Adr,
  input  logic [4:0]  R2Adr,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t             head_req, sel_req;
  wb_req_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]    valid;
  logic [AW-1:0]       head;
  logic                full, empty, push, pop, force_fifo, sel_we;
  logic [SW-1:0]       starve, starve_nxt;

  // Writes to $0 complete the handshake but are dropped here.
  assign mem_ready  = Rst_n & ~full;
  assign push       = mem_valid & mem_ready & (mem_adr != '0);
  assign force_fifo = ~empty & (starve == SW'(STARVE_LIMIT));

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(Clk), .rst_n(Rst_n), .push(push), .pop(pop),
    .wr('{adr: mem_adr, data: mem_data}), .rd(head_req),
    .full(full), .empty(empty), .entries(entries), .valid(valid), .head(head)
  );

  always_comb begin
    pop        = 1'b0;
    sel_we     = 1'b0;
    sel_req    = '{adr: alu_adr, data: alu_data};
    starve_nxt = starve;
    alu_stall  = 1'b0;
    if (alu_valid && !force_fifo) begin
      sel_we = (alu_adr != '0);
      if (!empty)               starve_nxt = starve + 1'b1;
      else if (alu_adr != '0)   starve_nxt = '0;
    end else if (!empty) begin
      pop        = 1'b1;
      sel_we     = 1'b1;
      sel_req    = head_req;
      starve_nxt = '0;
      alu_stall  = alu_valid;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      starve <= '0;
      WE     <= 1'b0;
      WAdr   <= '0;
      Din    <= '0;
    end else begin
      starve <= starve_nxt;
      WE     <= sel_we;
      if (sel_we) begin
        WAdr <= sel_req.adr;
        Din  <= sel_req.data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i]) pending = pending | adr_onehot(entries[i].adr);
    pending[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  logic [AW-1:0] idx;
  // Walk oldest to youngest so the last match is the newest value.
  always_comb begin
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (valid[idx] && R1Adr != '0 && entries[idx].adr == R1Adr) begin
        fwd1_hit  = 1'b1;
        fwd1_data = entries[idx].data;
      end
      if (valid[idx] && R2Adr != '0 && entries[idx].adr == R2Adr) begin
        fwd2_hit  = 1'b1;
        fwd2_data = entries[idx].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{R1Adr, R2Adr, head};
  assign fwd1_hit   = 1'b0;
  assign fwd2_hit   = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
`endif
endmodule
